// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch bus between pc_fetch_unit (master) and the instruction memory (slave).
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: IDLE -> FETCH -> EXEC loop, with a terminal TRAP
// on a misaligned next-PC. All outputs except PCPlus4 and imem_addr are registered.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   NextPCSrc,
  input  logic [31:0]            BranchTarget,
  input  logic                   IsJalr,
  input  logic                   Stall,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            Inst,
  output logic                   InstValid,
  output logic [31:0]            PC,
  output logic [31:0]            PCPlus4,
  output logic                   MisalignTrap,
  output logic [31:0]            RetireCount
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    TRAP
  } state_t;

  state_t      state;
  logic [31:0] redirect;
  logic [31:0] nxt;
  logic        nxt_misaligned;

  assign PCPlus4        = PC + 32'd4;
  assign imem.imem_addr = PC;

  // JALR targets have bit 0 forced low before the alignment check.
  always_comb begin
    redirect       = IsJalr ? {BranchTarget[31:1], 1'b0} : BranchTarget;
    nxt            = NextPCSrc ? redirect : PCPlus4;
    nxt_misaligned = (nxt[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      PC            <= RESET_PC;
      Inst          <= NOP_INST;
      InstValid     <= 1'b0;
      imem.imem_req <= 1'b0;
      MisalignTrap  <= 1'b0;
      RetireCount   <= '0;
    end else begin
      case (state)
        IDLE: begin
          state         <= FETCH;
          imem.imem_req <= 1'b1;
        end

        FETCH: begin
          if (imem.imem_ready) begin
            state         <= EXEC;
            Inst          <= imem.imem_rdata;
            InstValid     <= 1'b1;
            imem.imem_req <= 1'b0;
          end
        end

        EXEC: begin
          if (!Stall) begin
            Inst      <= NOP_INST;
            InstValid <= 1'b0;
            if (nxt_misaligned) begin
              state         <= TRAP;
              MisalignTrap  <= 1'b1;
              imem.imem_req <= 1'b0;
            end else begin
              state         <= FETCH;
              PC            <= nxt;
              RetireCount   <= RetireCount + 32'd1;
              imem.imem_req <= 1'b1;
            end
          end
        end

        TRAP: begin
          Inst          <= NOP_INST;
          InstValid     <= 1'b0;
          imem.imem_req <= 1'b0;
          MisalignTrap  <= 1'b1;
        end

        default: begin
          state         <= IDLE;
          imem.imem_req <= 1'b0;
          InstValid     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit: sequential fetch, branch, JALR, stall/wait, wrap, reset.
module tb_pc_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        NextPCSrc;
  logic [31:0] BranchTarget;
  logic        IsJalr;
  logic        Stall;
  logic [31:0] Inst;
  logic        InstValid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        MisalignTrap;
  logic [31:0] RetireCount;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .NextPCSrc    (NextPCSrc),
    .BranchTarget (BranchTarget),
    .IsJalr       (IsJalr),
    .Stall        (Stall),
    .imem         (bus.master),
    .Inst         (Inst),
    .InstValid    (InstValid),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .MisalignTrap (MisalignTrap),
    .RetireCount  (RetireCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; NextPCSrc = 1'b0; BranchTarget = '0; IsJalr = 1'b0; Stall = 1'b0;
    bus.imem_ready = 1'b0; bus.imem_rdata = '0;
    tick(); tick();
    n_checks++; if (PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", PC, 32'h0); end
    n_checks++; if (Inst !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h expected %h", Inst, NOP); end
    n_checks++; if (InstValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", InstValid); end
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
    n_checks++; if (MisalignTrap !== 1'b0) begin n_fail++; $display("FAIL reset_trap: got %b expected 0", MisalignTrap); end
    n_checks++; if (RetireCount !== 32'h0) begin n_fail++; $display("FAIL reset_retire: got %h expected 0", RetireCount); end
    n_checks++; if (PCPlus4 !== 32'h4) begin n_fail++; $display("FAIL reset_pcplus4: got %h expected 4", PCPlus4); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_sequential();
    logic [31:0] word;
    for (int i = 0; i < 3; i++) begin
      word = 32'h0010_0093 + i;
      n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_req[%0d]: got %b expected 1", i, bus.imem_req); end
      n_checks++; if (bus.imem_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, bus.imem_addr, 32'(i * 4)); end
      bus.imem_ready = 1'b1; bus.imem_rdata = word;
      tick();
      n_checks++; if (InstValid !== 1'b1 || Inst !== word || bus.imem_req !== 1'b0) begin
        n_fail++; $display("FAIL seq_exec[%0d]: got valid=%b inst=%h req=%b expected valid=1 inst=%h req=0", i, InstValid, Inst, bus.imem_req, word);
      end
      bus.imem_ready = 1'b0;
      tick();
      n_checks++; if (InstValid !== 1'b0 || Inst !== NOP || PC !== 32'((i + 1) * 4)) begin
        n_fail++; $display("FAIL seq_after[%0d]: got valid=%b inst=%h pc=%h expected valid=0 inst=%h pc=%h", i, InstValid, Inst, PC, NOP, 32'((i + 1) * 4));
      end
    end
    n_checks++; if (RetireCount !== 32'd3) begin n_fail++; $display("FAIL seq_retire: got %0d expected 3", RetireCount); end
  endtask

  task automatic test_branch();
    bus.imem_ready = 1'b1; tick();
    bus.imem_ready = 1'b0; tick();
    n_checks++; if (PC !== 32'h10) begin n_fail++; $display("FAIL br_pc_pre: got %h expected 10", PC); end
    bus.imem_ready = 1'b1; tick();
    bus.imem_ready = 1'b0;
    n_checks++; if (PCPlus4 !== 32'h14 || InstValid !== 1'b1) begin n_fail++; $display("FAIL br_exec: got pcplus4=%h valid=%b expected 14/1", PCPlus4, InstValid); end
    NextPCSrc = 1'b1; BranchTarget = 32'h40;
    tick();
    n_checks++; if (bus.imem_addr !== 32'h40 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL br_target: got addr=%h req=%b expected 40/1", bus.imem_addr, bus.imem_req); end
    n_checks++; if (RetireCount !== 32'd5) begin n_fail++; $display("FAIL br_retire: got %0d expected 5", RetireCount); end
    BranchTarget = 32'h200;
    tick();
    n_checks++; if (bus.imem_addr !== 32'h40) begin n_fail++; $display("FAIL br_ignored_in_fetch: got %h expected 40", bus.imem_addr); end
    NextPCSrc = 1'b0;
  endtask

  task automatic test_jalr();
    bus.imem_ready = 1'b1; tick();
    bus.imem_ready = 1'b0;
    NextPCSrc = 1'b1; IsJalr = 1'b1; BranchTarget = 32'h101;
    tick();
    n_checks++; if (PC !== 32'h100 || MisalignTrap !== 1'b0) begin n_fail++; $display("FAIL jalr_clear: got pc=%h trap=%b expected 100/0", PC, MisalignTrap); end
    n_checks++; if (RetireCount !== 32'd6) begin n_fail++; $display("FAIL jalr_retire: got %0d expected 6", RetireCount); end
    bus.imem_ready = 1'b1; tick();
    bus.imem_ready = 1'b0; BranchTarget = 32'h102;
    tick();
    n_checks++; if (MisalignTrap !== 1'b1 || PC !== 32'h100) begin n_fail++; $display("FAIL jalr_trap: got trap=%b pc=%h expected 1/100", MisalignTrap, PC); end
    n_checks++; if (RetireCount !== 32'd6 || InstValid !== 1'b0 || bus.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL jalr_trap_quiet: got retire=%0d valid=%b req=%b expected 6/0/0", RetireCount, InstValid, bus.imem_req);
    end
    NextPCSrc = 1'b0; IsJalr = 1'b0; bus.imem_ready = 1'b1; BranchTarget = 32'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (MisalignTrap !== 1'b1 || bus.imem_req !== 1'b0 || InstValid !== 1'b0 || PC !== 32'h100) begin
        n_fail++; $display("FAIL trap_terminal[%0d]: got trap=%b req=%b valid=%b pc=%h expected 1/0/0/100", i, MisalignTrap, bus.imem_req, InstValid, PC);
      end
    end
    bus.imem_ready = 1'b0;
  endtask

  task automatic test_stall_wait();
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wait_hold[%0d]: got req=%b addr=%h expected 1/0", i, bus.imem_req, bus.imem_addr); end
      tick();
    end
    bus.imem_ready = 1'b1; bus.imem_rdata = 32'h0050_0113;
    tick();
    Stall = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF; NextPCSrc = 1'b1; BranchTarget = 32'h80;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (InstValid !== 1'b1 || Inst !== 32'h0050_0113 || PC !== 32'h0) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got valid=%b inst=%h pc=%h expected 1/00500113/0", i, InstValid, Inst, PC);
      end
      BranchTarget = 32'h84;
    end
    Stall = 1'b0; NextPCSrc = 1'b0; bus.imem_ready = 1'b0;
    tick();
    n_checks++; if (PC !== 32'h4 || RetireCount !== 32'd1) begin n_fail++; $display("FAIL stall_release: got pc=%h retire=%0d expected 4/1", PC, RetireCount); end
  endtask

  task automatic test_wrap();
    bus.imem_ready = 1'b1; tick();
    bus.imem_ready = 1'b0; NextPCSrc = 1'b1; BranchTarget = 32'hFFFF_FFFC;
    tick();
    n_checks++; if (PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pre: got pc=%h pcplus4=%h expected fffffffc/0", PC, PCPlus4); end
    NextPCSrc = 1'b0; bus.imem_ready = 1'b1; tick();
    bus.imem_ready = 1'b0; tick();
    n_checks++; if (PC !== 32'h0 || MisalignTrap !== 1'b0 || bus.imem_req !== 1'b1) begin
      n_fail++; $display("FAIL wrap_pc: got pc=%h trap=%b req=%b expected 0/0/1", PC, MisalignTrap, bus.imem_req);
    end
    n_checks++; if (RetireCount !== 32'd3) begin n_fail++; $display("FAIL wrap_retire: got %0d expected 3", RetireCount); end
  endtask

  task automatic test_reset_mid_fetch();
    BranchTarget = 32'h0; tick();
    rst = 1'b1; tick();
    n_checks++; if (bus.imem_req !== 1'b0 || PC !== 32'h0 || RetireCount !== 32'h0) begin
      n_fail++; $display("FAIL rst_fetch: got req=%b pc=%h retire=%0d expected 0/0/0", bus.imem_req, PC, RetireCount);
    end
    rst = 1'b0; bus.imem_ready = 1'b1; bus.imem_rdata = 32'hCAFE_0000;
    tick();
    n_checks++; if (Inst !== NOP || InstValid !== 1'b0 || PC !== 32'h0) begin
      n_fail++; $display("FAIL rst_late_data: got inst=%h valid=%b pc=%h expected %h/0/0", Inst, InstValid, PC, NOP);
    end
    n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_refetch_req: got %b expected 1", bus.imem_req); end
    bus.imem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jalr();
    test_stall_wait();
    test_wrap();
    test_reset_mid_fetch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
